// File: rtl/alu_share_pkg.sv
// Shared definitions for the shared-ALU arbiter slice.
//
// Contents:
//   DEFAULT_DW - default operand/result width
//   op_e       - ALU operation codes (2 bits, matches the req_op encoding)
//   state_e    - arbiter FSM states
package alu_share_pkg;

    localparam int DEFAULT_DW = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU shared by all requesters of alu_share_arbiter.
//
// Ports:
//   op     - operation code (add, sub, and, or)
//   a, b   - DW-bit operands
//   result - DW-bit result; add/sub wrap modulo 2^DW
//   carry  - carry-out for add, borrow for sub, 0 for and/or
//            (only present when ALU_SHARE_FLAGS_EN is defined)
//
// Configuration macro: ALU_SHARE_FLAGS_EN
module alu_core
    import alu_share_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  op_e           op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result
`ifdef ALU_SHARE_FLAGS_EN
    ,
    output logic          carry
`endif
);

`ifdef ALU_SHARE_FLAGS_EN
    // One extra bit holds the carry (add) or borrow (sub) out of the MSB.
    localparam int EW = DW + 1;
`else
    localparam int EW = DW;
`endif

    logic [EW-1:0] ext;

    // Every op code produces a value, so there is no hold/latch path.
    always_comb begin
        ext = '0;
        case (op)
            OP_ADD:  ext = EW'(a) + EW'(b);
            OP_SUB:  ext = EW'(a) - EW'(b);
            OP_AND:  ext = EW'(a & b);
            OP_OR:   ext = EW'(a | b);
            default: ext = '0;
        endcase
    end

    assign result = ext[DW-1:0];

`ifdef ALU_SHARE_FLAGS_EN
    // For sub the zero-extended difference goes negative exactly when a < b,
    // so the top bit doubles as the borrow flag.
    assign carry = (op == OP_ADD || op == OP_SUB) ? ext[EW-1] : 1'b0;
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one ALU.
// One operation is in flight at a time: IDLE (grant) -> EXEC (compute) ->
// RESP (hold result until the consumer takes it).
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   req_valid  - per-requester request
//   req_ready  - one-hot grant, combinational, only in IDLE
//   req_op     - 2 bits per requester (00 add, 01 sub, 10 and, 11 or)
//   req_a/b    - DW bits per requester, slice i belongs to requester i
//   rsp_valid  - result available (held until rsp_ready)
//   rsp_ready  - consumer accepts result
//   rsp_id     - index of the requester owning the result
//   rsp_result - ALU result
//   rsp_zero   - result == 0           (ALU_SHARE_FLAGS_EN only)
//   rsp_carry  - carry/borrow flag     (ALU_SHARE_FLAGS_EN only)
//
// Configuration macro: ALU_SHARE_FLAGS_EN
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  DW      = DEFAULT_DW,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [2*NUM_REQ-1:0]  req_op,
    input  logic [DW*NUM_REQ-1:0] req_a,
    input  logic [DW*NUM_REQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [DW-1:0]         rsp_result
`ifdef ALU_SHARE_FLAGS_EN
    ,
    output logic                  rsp_zero,
    output logic                  rsp_carry
`endif
);

    state_e         state;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] cap_id;
    op_e            cap_op;
    logic [DW-1:0]  cap_a;
    logic [DW-1:0]  cap_b;

    logic           found;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] idx;
    logic [DW-1:0]  alu_result;
`ifdef ALU_SHARE_FLAGS_EN
    logic           alu_carry;
`endif

    // Round-robin search: scan from last_grant+1 around to last_grant itself,
    // so the most recently served requester has the lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Grant only while idle and out of reset; pending requests simply wait.
    always_comb begin
        req_ready = '0;
        if (!rst && state == ST_IDLE && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    alu_core #(
        .DW(DW)
    ) u_alu_core (
        .op     (cap_op),
        .a      (cap_a),
        .b      (cap_b),
        .result (alu_result)
`ifdef ALU_SHARE_FLAGS_EN
        ,
        .carry  (alu_carry)
`endif
    );

    // The requester's operands are captured on the grant edge so they may
    // change afterwards; rsp_* only move on the EXEC edge and stay frozen
    // through RESP however long the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= IDW'(NUM_REQ - 1);
            cap_id     <= '0;
            cap_op     <= OP_ADD;
            cap_a      <= '0;
            cap_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
`ifdef ALU_SHARE_FLAGS_EN
            rsp_zero   <= 1'b0;
            rsp_carry  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        last_grant <= winner;
                        cap_id     <= winner;
                        cap_op     <= op_e'(req_op[2*int'(winner) +: 2]);
                        cap_a      <= req_a[DW*int'(winner) +: DW];
                        cap_b      <= req_b[DW*int'(winner) +: DW];
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_id     <= cap_id;
                    rsp_valid  <= 1'b1;
`ifdef ALU_SHARE_FLAGS_EN
                    rsp_zero   <= (alu_result == '0);
                    rsp_carry  <= alu_carry;
`endif
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter (NUM_REQ=4, DW=8).
// A transaction-level model (round-robin pick, expected-response queue with
// due cycles) is compared against the DUT on every falling edge, and directed
// scenarios add hand-computed literal checks.
// Configuration macro honoured: ALU_SHARE_FLAGS_EN
module tb_alu_share_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [2*N-1:0] req_op;
    logic [DW*N-1:0] req_a;
    logic [DW*N-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [DW-1:0] rsp_result;
`ifdef ALU_SHARE_FLAGS_EN
    logic          rsp_zero;
    logic          rsp_carry;
`endif

    int compared   = 0;
    int mismatched = 0;

    alu_share_arbiter #(
        .NUM_REQ(N),
        .DW     (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_result(rsp_result)
`ifdef ALU_SHARE_FLAGS_EN
        ,
        .rsp_zero  (rsp_zero),
        .rsp_carry (rsp_carry)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         id;
        logic [7:0] res;
        logic       zero;
        logic       carry;
        int         due;
    } exp_t;

    exp_t q[$];
    int   mdl_busy = 0;
    int   mdl_last = N - 1;
    int   cyc      = 0;

    function automatic logic [7:0] aluModel(input int op, input int a, input int b);
        case (op)
            0:       return 8'((a + b) % 256);
            1:       return 8'((a - b + 256) % 256);
            2:       return 8'(a & b);
            default: return 8'(a | b);
        endcase
    endfunction

    function automatic logic carryModel(input int op, input int a, input int b);
        if (op == 0) return (a + b) > 255;
        if (op == 1) return a < b;
        return 1'b0;
    endfunction

    always @(negedge clk) begin : compare
        int   w;
        int   ix;
        logic exp_valid;
        logic [N-1:0] exp_ready;
        exp_t e;
        if (rst) begin
            q.delete();
            mdl_busy = 0;
            mdl_last = N - 1;
            checkOutput("rst_req_ready", 32'(req_ready), 0);
            checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
            checkOutput("rst_rsp_id", 32'(rsp_id), 0);
            checkOutput("rst_rsp_result", 32'(rsp_result), 0);
`ifdef ALU_SHARE_FLAGS_EN
            checkOutput("rst_rsp_zero", 32'(rsp_zero), 0);
            checkOutput("rst_rsp_carry", 32'(rsp_carry), 0);
`endif
        end else begin
            w = -1;
            exp_ready = '0;
            if (mdl_busy == 0) begin
                for (int k = 1; k <= N; k++) begin
                    ix = (mdl_last + k) % N;
                    if (w < 0 && req_valid[ix]) w = ix;
                end
            end
            if (w >= 0) exp_ready[w] = 1'b1;
            exp_valid = (q.size() > 0) && (cyc >= q[0].due);
            checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
                checkOutput("rsp_id", 32'(rsp_id), 32'(q[0].id));
                checkOutput("rsp_result", 32'(rsp_result), 32'(q[0].res));
`ifdef ALU_SHARE_FLAGS_EN
                checkOutput("rsp_zero", 32'(rsp_zero), 32'(q[0].zero));
                checkOutput("rsp_carry", 32'(rsp_carry), 32'(q[0].carry));
`endif
            end
            if (w >= 0) begin
                e.id    = w;
                e.res   = aluModel(int'(req_op[2*w +: 2]), int'(req_a[8*w +: 8]), int'(req_b[8*w +: 8]));
                e.zero  = (e.res == 8'h00);
                e.carry = carryModel(int'(req_op[2*w +: 2]), int'(req_a[8*w +: 8]), int'(req_b[8*w +: 8]));
                e.due   = cyc + 2;
                q.push_back(e);
                mdl_busy = 1;
                mdl_last = w;
            end
            if (exp_valid && rsp_ready) begin
                void'(q.pop_front());
                mdl_busy = 0;
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] valid, input logic [2*N-1:0] ops,
                                 input logic [DW*N-1:0] a, input logic [DW*N-1:0] b,
                                 input logic rdy);
        req_valid = valid;
        req_op    = ops;
        req_a     = a;
        req_b     = b;
        rsp_ready = rdy;
    endtask

    task automatic waitResp(input int limit, output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) checkOutput("resp_timeout", 0, 1);
    endtask

    task automatic singleOp(input int id, input logic [1:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] exp_res,
                            input logic exp_zero, input logic exp_carry);
        int n;
        applyStimulus(N'(1) << id, {N{op}}, {N{a}}, {N{b}}, 1'b1);
        @(negedge clk);
        checkOutput("single_grant", 32'(req_ready), 32'(N'(1) << id));
        tick();
        req_valid = '0;
        waitResp(8, n);
        checkOutput("single_latency", n, 2);
        checkOutput("single_id", 32'(rsp_id), id);
        checkOutput("single_result", 32'(rsp_result), 32'(exp_res));
`ifdef ALU_SHARE_FLAGS_EN
        checkOutput("single_zero", 32'(rsp_zero), 32'(exp_zero));
        checkOutput("single_carry", 32'(rsp_carry), 32'(exp_carry));
`else
        if (exp_zero && exp_carry) $display("[TB] note: flags not built in");
`endif
        tick();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : stimulus
        int gid[$];
        int gcyc[$];
        int n;
        int snap_id;
        logic [7:0] snap_res;
        int exp_order[5];

        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        applyStimulus(4'hF, 8'h00, 32'h0, 32'h0, 1'b1);
        tick();
        tick();
        req_valid = '0;
        tick();
        rst = 1'b0;
        tick();

        singleOp(0, 2'b00, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1);
        singleOp(1, 2'b01, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1);
        singleOp(2, 2'b10, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0);
        singleOp(3, 2'b11, 8'h0A, 8'h50, 8'h5A, 1'b0, 1'b0);

        // all four requesting continuously after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(4'hF, {2'b11, 2'b10, 2'b01, 2'b00},
                      {8'h11, 8'h22, 8'h33, 8'h44}, {8'h0F, 8'hF0, 8'h50, 8'hC0}, 1'b1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            for (int j = 0; j < N; j++) begin
                if (req_ready[j]) begin
                    gid.push_back(j);
                    gcyc.push_back(i);
                end
            end
        end
        checkOutput("rr_grant_count", gid.size(), 5);
        for (int i = 0; i < 5 && i < gid.size(); i++) begin
            checkOutput("rr_grant_order", gid[i], exp_order[i]);
            checkOutput("rr_grant_spacing", gcyc[i], 3 * i);
        end
        tick();

        // consumer stalls for 10 cycles with requests pending
        rsp_ready = 1'b0;
        waitResp(6, n);
        snap_id  = int'(rsp_id);
        snap_res = rsp_result;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(rsp_valid), 1);
            checkOutput("stall_id", 32'(rsp_id), snap_id);
            checkOutput("stall_result", 32'(rsp_result), 32'(snap_res));
            checkOutput("stall_ready", 32'(req_ready), 0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("grant_after_stall", 32'(req_ready), 32'(N'(1) << ((snap_id + 1) % N)));
        tick();

        // reset while the granted operation is in EXEC
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_grant", 32'(req_ready), 32'h1);
        checkOutput("post_rst_valid", 32'(rsp_valid), 0);
        tick();
        for (int i = 0; i < 6; i++) tick();
        req_valid = '0;
        for (int i = 0; i < 8; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
